// File: rtl/wb_writeback_unit_if.sv
// MEM/WB writeback bundle and the register-file write ports of the writeback stage.
// The slave side is the writeback unit; the master side is the pipeline/register files.
interface wb_writeback_unit_if #(
  parameter int RET_W = 32
);
  logic             wb_valid;
  logic [31:0]      aluResultWb;
  logic [31:0]      memDataWb;
  logic [4:0]       rWWb;
  logic [1:0]       wrCtrlWb;
  logic [63:0]      fp_busW;
  logic             fp_regWr;
  logic             fp_double;

  logic             memwb_write;
  logic             regWr;
  logic [4:0]       rW;
  logic [31:0]      busW;
  logic             fpWrEn;
  logic [4:0]       fpRW;
  logic [31:0]      fpBusW;
  logic             fp_misalign;
  logic [RET_W-1:0] retired;

  modport master (
    output wb_valid, aluResultWb, memDataWb, rWWb, wrCtrlWb, fp_busW, fp_regWr, fp_double,
    input  memwb_write, regWr, rW, busW, fpWrEn, fpRW, fpBusW, fp_misalign, retired
  );

  modport slave (
    input  wb_valid, aluResultWb, memDataWb, rWWb, wrCtrlWb, fp_busW, fp_regWr, fp_double,
    output memwb_write, regWr, rW, busW, fpWrEn, fpRW, fpBusW, fp_misalign, retired
  );
endinterface

// File: rtl/wb_writeback_unit.sv
// Writeback stage: drives the integer and 32-bit FP register-file write ports from MEM/WB,
// splitting FP doubles into high-then-low writes to an even/odd pair, and counts retirements.
module wb_writeback_unit #(
  parameter int RET_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_writeback_unit_if.slave  bus
);

  typedef enum logic {
    IDLE,
    LO_HALF
  } state_t;

  state_t           state;
  logic             reg_wr;
  logic [4:0]       rw_q;
  logic [31:0]      busw_q;
  logic             fp_wr;
  logic [4:0]       fp_rw;
  logic [31:0]      fp_bus;
  logic             misalign;
  logic [RET_W-1:0] retired_q;
  logic [3:0]       pair_base;
  logic [31:0]      lo_word;
  logic [31:0]      int_data;
  logic             is_double;

  always_comb begin
    int_data = bus.aluResultWb;
    case (bus.wrCtrlWb)
      2'b10:   int_data = bus.memDataWb;
      2'b11:   int_data = {{16{bus.memDataWb[15]}}, bus.memDataWb[15:0]};
      default: int_data = bus.aluResultWb;
    endcase
  end

  // Holding MEM/WB for one extra cycle lets the low half go out while the bundle is still parked.
  assign is_double       = bus.wb_valid && bus.fp_regWr && bus.fp_double;
  assign bus.memwb_write = !((state == IDLE) && is_double);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reg_wr    <= 1'b0;
      rw_q      <= 5'd0;
      busw_q    <= 32'd0;
      fp_wr     <= 1'b0;
      fp_rw     <= 5'd0;
      fp_bus    <= 32'd0;
      misalign  <= 1'b0;
      retired_q <= '0;
      pair_base <= 4'd0;
      lo_word   <= 32'd0;
    end else begin
      reg_wr   <= 1'b0;
      fp_wr    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wb_valid) begin
            reg_wr <= (bus.wrCtrlWb != 2'b00) && (bus.rWWb != 5'd0);
            rw_q   <= bus.rWWb;
            busw_q <= int_data;
            if (bus.fp_regWr) begin
              fp_wr <= 1'b1;
              if (bus.fp_double) begin
                // The pair base always has LSB 0; an odd request is flagged but still lands on the pair.
                fp_rw     <= {bus.rWWb[4:1], 1'b0};
                fp_bus    <= bus.fp_busW[63:32];
                lo_word   <= bus.fp_busW[31:0];
                pair_base <= bus.rWWb[4:1];
                misalign  <= bus.rWWb[0];
                state     <= LO_HALF;
              end else begin
                fp_rw     <= bus.rWWb;
                fp_bus    <= bus.fp_busW[31:0];
                retired_q <= retired_q + RET_W'(1);
              end
            end else begin
              retired_q <= retired_q + RET_W'(1);
            end
          end
        end
        LO_HALF: begin
          fp_wr     <= 1'b1;
          fp_rw     <= {pair_base, 1'b1};
          fp_bus    <= lo_word;
          retired_q <= retired_q + RET_W'(1);
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.regWr       = reg_wr;
  assign bus.rW          = rw_q;
  assign bus.busW        = busw_q;
  assign bus.fpWrEn      = fp_wr;
  assign bus.fpRW        = fp_rw;
  assign bus.fpBusW      = fp_bus;
  assign bus.fp_misalign = misalign;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: table of single-cycle instructions plus hand-built double,
// reset-during-split and counter-wrap sequences, all checked through an expected-result queue.
module tb_wb_writeback_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_writeback_unit_if #(.RET_W(32)) bus ();
  wb_writeback_unit_if #(.RET_W(4))  bus_s ();

  // A narrow-counter copy sees the same instruction stream so the wrap can be reached quickly.
  assign bus_s.wb_valid    = bus.wb_valid;
  assign bus_s.aluResultWb = bus.aluResultWb;
  assign bus_s.memDataWb   = bus.memDataWb;
  assign bus_s.rWWb        = bus.rWWb;
  assign bus_s.wrCtrlWb    = bus.wrCtrlWb;
  assign bus_s.fp_busW     = bus.fp_busW;
  assign bus_s.fp_regWr    = bus.fp_regWr;
  assign bus_s.fp_double   = bus.fp_double;

  wb_writeback_unit #(.RET_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  wb_writeback_unit #(.RET_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rw;
    logic [1:0]  ctrl;
    logic [63:0] fpb;
    logic        fpwr;
    logic        dbl;
    logic        e_reg_wr;
    logic [31:0] e_busw;
    logic        e_fp_wr;
    logic [4:0]  e_fp_rw;
    logic [31:0] e_fp_bus;
    logic        retires;
  } vec_t;

  typedef struct {
    logic        reg_wr;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic        fp_wr;
    logic [4:0]  fp_rw;
    logic [31:0] fp_bus;
    logic        mis;
    logic [31:0] ret;
  } exp_t;

  localparam int NV = 10;
  vec_t        vecs [NV];
  exp_t        exp_q [$];
  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_retired;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
  endtask

  function automatic exp_t mkExp(input logic reg_wr, input logic [4:0] rw, input logic [31:0] busw,
                                 input logic fp_wr, input logic [4:0] fp_rw, input logic [31:0] fp_bus,
                                 input logic mis, input logic [31:0] ret);
    exp_t e;
    e.reg_wr = reg_wr; e.rw = rw; e.busw = busw;
    e.fp_wr = fp_wr; e.fp_rw = fp_rw; e.fp_bus = fp_bus;
    e.mis = mis; e.ret = ret;
    return e;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.wb_valid    = v.valid;
    bus.aluResultWb = v.alu;
    bus.memDataWb   = v.mem;
    bus.rWWb        = v.rw;
    bus.wrCtrlWb    = v.ctrl;
    bus.fp_busW     = v.fpb;
    bus.fp_regWr    = v.fpwr;
    bus.fp_double   = v.dbl;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("[TB] FAIL scoreboard_underflow: got empty queue, want an entry");
      return;
    end
    e = exp_q.pop_front();
    checkVal("regWr", 32'(bus.regWr), 32'(e.reg_wr));
    if (e.reg_wr) begin
      checkVal("rW", 32'(bus.rW), 32'(e.rw));
      checkVal("busW", bus.busW, e.busw);
    end
    checkVal("fpWrEn", 32'(bus.fpWrEn), 32'(e.fp_wr));
    if (e.fp_wr) begin
      checkVal("fpRW", 32'(bus.fpRW), 32'(e.fp_rw));
      checkVal("fpBusW", bus.fpBusW, e.fp_bus);
    end
    checkVal("fp_misalign", 32'(bus.fp_misalign), 32'(e.mis));
    checkVal("retired", bus.retired, e.ret);
    checkVal("retired_narrow", 32'(bus_s.retired), 32'(e.ret[3:0]));
  endtask

  task automatic expectCycle(input exp_t e, input logic mw);
    #1;
    checkVal("memwb_write", 32'(bus.memwb_write), 32'(mw));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_regWr"}, 32'(bus.regWr), 32'd0);
    checkVal({tag, "_rW"}, 32'(bus.rW), 32'd0);
    checkVal({tag, "_busW"}, bus.busW, 32'd0);
    checkVal({tag, "_fpWrEn"}, 32'(bus.fpWrEn), 32'd0);
    checkVal({tag, "_fpRW"}, 32'(bus.fpRW), 32'd0);
    checkVal({tag, "_fpBusW"}, bus.fpBusW, 32'd0);
    checkVal({tag, "_fp_misalign"}, 32'(bus.fp_misalign), 32'd0);
    checkVal({tag, "_retired"}, bus.retired, 32'd0);
    checkVal({tag, "_retired_narrow"}, 32'(bus_s.retired), 32'd0);
    checkVal({tag, "_memwb_write"}, 32'(bus.memwb_write), 32'd1);
  endtask

  // High word to the even register now, low word to the odd register on the following edge.
  task automatic doubleSeq(input logic [4:0] rw, input logic [63:0] fpb,
                           input logic [1:0] ctrl, input logic [31:0] alu);
    vec_t        v;
    logic        int_en;
    logic [4:0]  even_rw;
    logic [4:0]  odd_rw;
    int_en  = (ctrl == 2'b01) && (rw != 5'd0);
    even_rw = {rw[4:1], 1'b0};
    odd_rw  = {rw[4:1], 1'b1};
    v = '{1'b1, alu, 32'd0, rw, ctrl, fpb, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0};
    applyStimulus(v);
    expectCycle(mkExp(int_en, rw, alu, 1'b1, even_rw, fpb[63:32], rw[0], exp_retired), 1'b0);
    @(negedge clk);
    exp_retired++;
    expectCycle(mkExp(1'b0, 5'd0, 32'd0, 1'b1, odd_rw, fpb[31:0], 1'b0, exp_retired), 1'b1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 32'h0000_1234, 32'h0, 5'd5, 2'b01, 64'h0, 1'b0, 1'b0,
                1'b1, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 32'h0, 32'h0000_8001, 5'd7, 2'b11, 64'h0, 1'b0, 1'b0,
                1'b1, 32'hFFFF_8001, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[2] = '{1'b1, 32'h0, 32'h0000_8001, 5'd0, 2'b11, 64'h0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_9999, 32'hDEAD_BEEF, 5'd31, 2'b10, 64'h0, 1'b0, 1'b0,
                1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0077, 32'h0, 5'd3, 2'b00, 64'h0, 1'b0, 1'b0,
                1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0055, 32'h0, 5'd2, 2'b01, 64'h1111_2222_3333_4444, 1'b1, 1'b0,
                1'b1, 32'h0000_0055, 1'b1, 5'd2, 32'h3333_4444, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0066, 32'h0, 5'd5, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 32'h0, 32'h1234_7FFF, 5'd9, 2'b11, 64'h0, 1'b0, 1'b0,
                1'b1, 32'h0000_7FFF, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_CAFE, 32'h0, 5'd20, 2'b01, 64'h5, 1'b0, 1'b1,
                1'b1, 32'h0000_CAFE, 1'b0, 5'd0, 32'h0, 1'b1};
    vecs[9] = '{1'b1, 32'h0, 32'h0, 5'd31, 2'b00, 64'hABCD_0000_1357_9BDF, 1'b1, 1'b0,
                1'b0, 32'h0, 1'b1, 5'd31, 32'h1357_9BDF, 1'b1};

    v = '{1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    bus.wb_valid = 1'b0; bus.aluResultWb = 32'd0; bus.memDataWb = 32'd0; bus.rWWb = 5'd0;
    bus.wrCtrlWb = 2'b00; bus.fp_busW = 64'd0; bus.fp_regWr = 1'b0; bus.fp_double = 1'b0;
    exp_retired = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].retires) exp_retired++;
      expectCycle(mkExp(vecs[i].e_reg_wr, vecs[i].rw, vecs[i].e_busw, vecs[i].e_fp_wr,
                        vecs[i].e_fp_rw, vecs[i].e_fp_bus, 1'b0, exp_retired), 1'b1);
    end

    doubleSeq(5'd4, 64'hAAAA_BBBB_CCCC_DDDD, 2'b01, 32'h0000_4444);
    doubleSeq(5'd9, 64'h0123_4567_89AB_CDEF, 2'b00, 32'h0);
    doubleSeq(5'd10, 64'h1020_3040_5060_7080, 2'b00, 32'h0);
    doubleSeq(5'd3, 64'h9999_8888_7777_6666, 2'b01, 32'h0000_0303);
    applyStimulus(vecs[0]);
    exp_retired++;
    expectCycle(mkExp(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0, exp_retired), 1'b1);

    // Reset lands while the low half is pending; that write must never appear.
    v = '{1'b1, 32'h0, 32'h0, 5'd14, 2'b00, 64'hFEED_FACE_0BAD_F00D, 1'b1, 1'b1,
          1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
    applyStimulus(v);
    expectCycle(mkExp(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hFEED_FACE, 1'b0, exp_retired), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.wb_valid = 1'b0;
    exp_retired = 32'd0;
    #1;
    checkResetState("mid_split_reset");
    @(posedge clk);
    #1;
    checkResetState("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[6]);
    expectCycle(mkExp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, exp_retired), 1'b1);
    applyStimulus(vecs[0]);
    exp_retired++;
    expectCycle(mkExp(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0, exp_retired), 1'b1);

    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 2) begin
        v = '{1'b0, 32'(i), 32'h0, 5'(i), 2'b01, {32'(i), ~32'(i)}, 1'b1, 1'b0,
              1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0};
      end else begin
        v = '{1'b1, 32'(i), 32'h0, 5'(i), 2'b00, {32'(i), ~32'(i)}, 1'b1, 1'b0,
              1'b0, 32'h0, 1'b1, 5'(i), ~32'(i), 1'b1};
      end
      applyStimulus(v);
      if (v.retires) exp_retired++;
      expectCycle(mkExp(1'b0, 5'd0, 32'h0, v.e_fp_wr, v.e_fp_rw, v.e_fp_bus, 1'b0, exp_retired), 1'b1);
      if (v.retires && exp_retired == 32'd16) checkVal("narrow_wrap_to_zero", 32'(bus_s.retired), 32'd0);
    end

    checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
